// File: rtl/branch_sequencer_if.sv
// Branch request bus between decode (master) and the branch sequencer (slave).
interface branch_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             br_valid;
  logic             br_ready;
  logic [1:0]       br_op;
  logic             br_signed;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] br_pc;

  modport master (
    output br_valid, br_op, br_signed, cmp_a, cmp_b, br_offset, br_pc,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_op, br_signed, cmp_a, cmp_b, br_offset, br_pc,
    output br_ready
  );
endinterface

// File: rtl/branch_sequencer.sv
// Program counter owner: sequential advance, and JMP/JLT/JGT/JEQ resolved in a
// registered compare stage followed by a counted fetch/decode flush on redirect.
module branch_sequencer #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  branch_sequencer_if.slave br,
  output logic [WIDTH-1:0]  pc,
  output logic              busy,
  output logic              flush,
  output logic              taken,
  output logic              not_taken
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_EVAL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0]       OP_JMP     = 2'b00;
  localparam logic [1:0]       OP_JLT     = 2'b01;
  localparam logic [1:0]       OP_JGT     = 2'b10;
  localparam logic [WIDTH-1:0] PC_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [1:0]       op_q, op_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] off_q, off_d;
  logic [WIDTH-1:0] bpc_q, bpc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic             not_taken_q, not_taken_d;

  // Branch condition; JEQ ignores signedness, JLT/JGT honour it.
  function automatic logic cond_true(input logic [1:0]       op,
                                     input logic             sgn,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    lt;
    logic                    gt;
    sa = $signed(a);
    sb = $signed(b);
    lt = sgn ? (sa < sb) : (a < b);
    gt = sgn ? (sa > sb) : (a > b);
    case (op)
      OP_JMP:  cond_true = 1'b1;
      OP_JLT:  cond_true = lt;
      OP_JGT:  cond_true = gt;
      default: cond_true = (a == b);
    endcase
  endfunction

  // Redirect address: branch address plus signed offset, wrapping at WIDTH bits.
  function automatic logic [WIDTH-1:0] branch_target(input logic [WIDTH-1:0] base,
                                                     input logic [WIDTH-1:0] off);
    logic signed [WIDTH-1:0] sum;
    sum = $signed(base) + $signed(off);
    branch_target = $unsigned(sum);
  endfunction

  // Next-state, PC update and request latching.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    sgn_d       = sgn_q;
    a_d         = a_q;
    b_d         = b_q;
    off_d       = off_q;
    bpc_d       = bpc_q;
    cnt_d       = cnt_q;
    taken_d     = 1'b0;
    not_taken_d = 1'b0;
    br.br_ready = 1'b0;
    case (state_q)
      S_RUN: begin
        br.br_ready = 1'b1;
        if (advance) begin
          pc_d = pc_q + PC_ONE;
        end
        if (br.br_valid) begin
          op_d    = br.br_op;
          sgn_d   = br.br_signed;
          a_d     = br.cmp_a;
          b_d     = br.cmp_b;
          off_d   = br.br_offset;
          bpc_d   = br.br_pc;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (cond_true(op_q, sgn_q, a_q, b_q)) begin
          pc_d    = branch_target(bpc_q, off_q);
          taken_d = 1'b1;
          cnt_d   = FLUSH_LOAD;
          state_d = S_FLUSH;
        end else begin
          not_taken_d = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_FLUSH: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State, PC, latched request and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      op_q        <= '0;
      sgn_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      off_q       <= '0;
      bpc_q       <= '0;
      cnt_q       <= '0;
      taken_q     <= 1'b0;
      not_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      sgn_q       <= sgn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      off_q       <= off_d;
      bpc_q       <= bpc_d;
      cnt_q       <= cnt_d;
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  assign pc        = pc_q;
  assign busy      = (state_q != S_RUN);
  assign flush     = (state_q == S_FLUSH);
  assign taken     = taken_q;
  assign not_taken = not_taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus random
// branches compared against a transaction-level reference of the PC rules.
module tb_branch_sequencer;

  localparam int FC = 2;

  typedef struct packed {
    logic [1:0]  op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] off;
    logic [15:0] bpc;
  } req_t;

  logic        clk;
  logic        rst;
  logic        advance;
  logic [15:0] pc;
  logic        busy;
  logic        flush;
  logic        taken;
  logic        not_taken;

  int          checks;
  int          errors;
  logic [15:0] mpc;

  branch_sequencer_if #(.WIDTH(16)) bif ();

  branch_sequencer #(
    .WIDTH(16),
    .RESET_PC(16'h0000),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .advance(advance),
    .br(bif),
    .pc(pc),
    .busy(busy),
    .flush(flush),
    .taken(taken),
    .not_taken(not_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_int(input logic [15:0] v, input bit sgn);
    int r;
    r = int'(v);
    if (sgn && r >= 32768) r = r - 65536;
    return r;
  endfunction

  function automatic bit ref_cond(input req_t r);
    int ai;
    int bi;
    ai = to_int(r.a, r.sgn);
    bi = to_int(r.b, r.sgn);
    case (r.op)
      2'b00:   return 1'b1;
      2'b01:   return ai < bi;
      2'b10:   return ai > bi;
      default: return r.a == r.b;
    endcase
  endfunction

  function automatic logic [15:0] ref_target(input req_t r);
    int t;
    t = (int'(r.bpc) + to_int(r.off, 1'b1) + 65536) % 65536;
    return 16'(t);
  endfunction

  task automatic drive(input req_t r);
    bif.br_op     = r.op;
    bif.br_signed = r.sgn;
    bif.cmp_a     = r.a;
    bif.cmp_b     = r.b;
    bif.br_offset = r.off;
    bif.br_pc     = r.bpc;
  endtask

  task automatic adv_n(input int n);
    for (int i = 0; i < n; i++) begin
      advance = 1'b1;
      step();
      mpc = mpc + 16'd1;
      chk("adv_pc", 32'(pc), 32'(mpc));
    end
    advance = 1'b0;
  endtask

  // Presents r in RUN and follows it to completion; optionally leaves nr
  // presented (held through EVAL/FLUSH) for the next call to pick up.
  task automatic do_branch(input req_t r, input bit adv0, input bit nv, input req_t nr);
    bit          tk;
    logic [15:0] tgt;
    tk  = ref_cond(r);
    tgt = ref_target(r);
    drive(r);
    bif.br_valid = 1'b1;
    advance      = adv0;
    step();
    if (adv0) mpc = mpc + 16'd1;
    chk("eval_pc", 32'(pc), 32'(mpc));
    chk("eval_busy", 32'(busy), 32'd1);
    chk("eval_ready", 32'(bif.br_ready), 32'd0);
    chk("eval_flush", 32'(flush), 32'd0);
    chk("eval_pulses", {30'd0, taken, not_taken}, 32'd0);
    bif.br_valid = nv;
    if (nv) drive(nr);
    advance = 1'b1;
    step();
    if (tk) begin
      mpc = tgt;
      chk("tk_pc", 32'(pc), 32'(mpc));
      chk("tk_taken", 32'(taken), 32'd1);
      chk("tk_not_taken", 32'(not_taken), 32'd0);
      chk("tk_flush", 32'(flush), 32'd1);
      chk("tk_ready", 32'(bif.br_ready), 32'd0);
      for (int k = 2; k <= FC; k++) begin
        step();
        chk("fl_flush", 32'(flush), 32'd1);
        chk("fl_taken", 32'(taken), 32'd0);
        chk("fl_pc", 32'(pc), 32'(mpc));
        chk("fl_ready", 32'(bif.br_ready), 32'd0);
      end
      step();
      chk("end_flush", 32'(flush), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_ready", 32'(bif.br_ready), 32'd1);
      chk("end_pc", 32'(pc), 32'(mpc));
      chk("end_taken", 32'(taken), 32'd0);
    end else begin
      chk("nt_pc", 32'(pc), 32'(mpc));
      chk("nt_not_taken", 32'(not_taken), 32'd1);
      chk("nt_taken", 32'(taken), 32'd0);
      chk("nt_flush", 32'(flush), 32'd0);
      chk("nt_ready", 32'(bif.br_ready), 32'd1);
      chk("nt_busy", 32'(busy), 32'd0);
    end
    advance = 1'b0;
  endtask

  initial begin
    req_t r;
    req_t r2;
    req_t none;
    checks = 0;
    errors = 0;
    none   = '0;
    rst          = 1'b1;
    advance      = 1'b1;
    bif.br_valid = 1'b0;
    drive(none);

    // Reset held two cycles with advance high
    step();
    step();
    mpc = 16'h0000;
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_ready", 32'(bif.br_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", {30'd0, taken, not_taken}, 32'd0);
    rst = 1'b0;
    adv_n(3);
    chk("three_adv", 32'(pc), 32'h0003);

    // Wrap-around from 0xFFFE via self-jump
    r = '{op: 2'b00, sgn: 1'b0, a: 16'h0, b: 16'h0, off: 16'h0000, bpc: 16'hFFFE};
    do_branch(r, 1'b0, 1'b0, none);
    chk("self_jump", 32'(pc), 32'hFFFE);
    adv_n(2);
    chk("wrap", 32'(pc), 32'h0000);

    // JMP backwards by 16
    r = '{op: 2'b00, sgn: 1'b0, a: 16'h0, b: 16'h0, off: 16'hFFF0, bpc: 16'h0010};
    do_branch(r, 1'b0, 1'b0, none);
    chk("jmp_back", 32'(pc), 32'h0000);

    // Signed versus unsigned JLT
    r = '{op: 2'b01, sgn: 1'b1, a: 16'hFFFF, b: 16'h0001, off: 16'h0020, bpc: 16'h0100};
    do_branch(r, 1'b0, 1'b0, none);
    chk("jlt_signed", 32'(pc), 32'h0120);
    r.sgn = 1'b0;
    do_branch(r, 1'b0, 1'b0, none);
    chk("jlt_unsigned", 32'(pc), 32'h0120);

    // JEQ taken, JGT on equal operands not taken
    r = '{op: 2'b11, sgn: 1'b1, a: 16'h1234, b: 16'h1234, off: 16'h0004, bpc: 16'h2000};
    do_branch(r, 1'b1, 1'b0, none);
    chk("jeq", 32'(pc), 32'h2004);
    r = '{op: 2'b10, sgn: 1'b0, a: 16'h0005, b: 16'h0005, off: 16'h0100, bpc: 16'h3000};
    do_branch(r, 1'b0, 1'b0, none);
    chk("jgt_eq", 32'(pc), 32'h2004);

    // Second request held through FLUSH, then one held past a not-taken
    r  = '{op: 2'b00, sgn: 1'b0, a: 16'h0, b: 16'h0, off: 16'h0008, bpc: 16'h0400};
    r2 = '{op: 2'b10, sgn: 1'b1, a: 16'h0001, b: 16'h8000, off: 16'hFFFC, bpc: 16'h0500};
    do_branch(r, 1'b0, 1'b1, r2);
    chk("b2b_first", 32'(pc), 32'h0408);
    r = '{op: 2'b01, sgn: 1'b0, a: 16'h0009, b: 16'h0002, off: 16'h0010, bpc: 16'h0600};
    do_branch(r2, 1'b0, 1'b1, r);
    chk("b2b_second", 32'(pc), 32'h04FC);
    do_branch(r, 1'b0, 1'b0, none);
    chk("b2b_third", 32'(pc), 32'h04FC);

    // Reset during the EVAL cycle of a taken JMP
    r = '{op: 2'b00, sgn: 1'b0, a: 16'h0, b: 16'h0, off: 16'h0004, bpc: 16'h0040};
    drive(r);
    bif.br_valid = 1'b1;
    step();
    chk("rst_eval_busy", 32'(busy), 32'd1);
    bif.br_valid = 1'b0;
    rst = 1'b1;
    step();
    mpc = 16'h0000;
    chk("rst_eval_pc", 32'(pc), 32'h0000);
    chk("rst_eval_taken", 32'(taken), 32'd0);
    chk("rst_eval_flush", 32'(flush), 32'd0);
    chk("rst_eval_ready", 32'(bif.br_ready), 32'd1);
    rst = 1'b0;
    step();
    chk("post_rst_taken", 32'(taken), 32'd0);
    chk("post_rst_flush", 32'(flush), 32'd0);
    chk("post_rst_pc", 32'(pc), 32'h0000);

    // Random branches against the reference
    for (int i = 0; i < 40; i++) begin
      r.op  = 2'($urandom);
      r.sgn = 1'($urandom);
      r.a   = 16'($urandom);
      r.b   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r.b = r.a;
      r.off = 16'($urandom);
      r.bpc = 16'($urandom);
      adv_n(int'($urandom_range(0, 2)));
      do_branch(r, 1'($urandom), 1'b0, none);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
